// File: rtl/hist_builder_mp.sv
// Multi-pixel timestamp histogram builder: accumulates interleaved samples, then scans each pixel for its peak bin.
// Optional macro HIST_SAT_EN: bin counters saturate instead of wrapping.
module hist_builder_mp #(
  parameter int unsigned NP        = 10,
  parameter int unsigned BIN_W     = 6,
  parameter int unsigned PIXEL_NUM = 3,
  parameter int unsigned ACQ_NUM   = 4,
  parameter int unsigned CNT_W     = 4,
  localparam int unsigned PIX_W    = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1
) (
  input  logic               clk,
  input  logic               res,
  input  logic               wr_en,
  input  logic [NP-1:0]      data,
  output logic               ready,
  output logic               peak_valid,
  input  logic               peak_ready,
  output logic [PIX_W-1:0]   peak_pixel,
  output logic [BIN_W-1:0]   peak_bin,
  output logic [CNT_W-1:0]   peak_count,
  output logic               drop_flag
);

  localparam int unsigned BINS   = 2 ** BIN_W;
  localparam int unsigned DEPTH  = PIXEL_NUM * BINS;
  localparam int unsigned ADDR_W = PIX_W + BIN_W;
  localparam int unsigned ACQ_W  = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

  typedef enum logic [1:0] {INIT, ACCUM, SCAN, OUT} state_t;

  state_t state, stateNext;

  logic [CNT_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] initCnt;
  logic [PIX_W-1:0]  pixCnt;
  logic [ACQ_W-1:0]  acqCnt;
  logic [PIX_W-1:0]  scanPix;
  logic [BIN_W-1:0]  scanBin;
  logic [BIN_W-1:0]  maxBin;
  logic [CNT_W-1:0]  maxCnt;
  logic              closing;
  logic              s1Valid, s2Valid;
  logic [ADDR_W-1:0] s1Addr, s2Addr;
  logic [CNT_W-1:0]  s2Data;

  logic              accept, lastSlot, initDone, scanLast, scanHigher;
  logic              transfer, pipeEmpty, lastPix, dataHit;
  logic [BIN_W-1:0]  sampleBin;
  logic [ADDR_W-1:0] scanAddr;
  logic [CNT_W-1:0]  scanRd;
  logic              closingNext, readyNext, peakLoad;

  function automatic logic [CNT_W-1:0] incCnt(input logic [CNT_W-1:0] c);
`ifdef HIST_SAT_EN
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  assign accept     = wr_en && ready;
  assign lastSlot   = (pixCnt == PIX_W'(PIXEL_NUM - 1)) && (acqCnt == ACQ_W'(ACQ_NUM - 1));
  assign dataHit    = (data != '0);
  assign sampleBin  = data[NP-1 -: BIN_W];
  assign initDone   = (initCnt == ADDR_W'(DEPTH - 1));
  assign scanAddr   = {scanPix, scanBin};
  assign scanRd     = mem[scanAddr];
  assign scanLast   = (scanBin == BIN_W'(BINS - 1));
  assign scanHigher = (scanRd > maxCnt);
  assign transfer   = peak_valid && peak_ready;
  assign pipeEmpty  = !s1Valid && !s2Valid;
  assign lastPix    = (scanPix == PIX_W'(PIXEL_NUM - 1));

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) state <= INIT;
    else     state <= stateNext;
  end

  // Next-state logic; ACCUM waits for the increment pipeline to drain before scanning
  always_comb begin
    stateNext = state;
    unique case (state)
      INIT:  if (initDone) stateNext = ACCUM;
      ACCUM: if (closing && pipeEmpty) stateNext = SCAN;
      SCAN:  if (scanLast) stateNext = OUT;
      OUT:   if (transfer) stateNext = lastPix ? ACCUM : SCAN;
      default: stateNext = INIT;
    endcase
  end

  // Output/control decode
  always_comb begin
    closingNext = 1'b0;
    readyNext   = 1'b0;
    peakLoad    = 1'b0;
    if (stateNext == ACCUM)
      closingNext = (state == ACCUM) && (closing || (accept && lastSlot));
    readyNext = (stateNext == ACCUM) && !closingNext;
    peakLoad  = (state == SCAN) && scanLast;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ready      <= 1'b0;
      closing    <= 1'b0;
      initCnt    <= '0;
      pixCnt     <= '0;
      acqCnt     <= '0;
      scanPix    <= '0;
      scanBin    <= '0;
      maxBin     <= '0;
      maxCnt     <= '0;
      peak_valid <= 1'b0;
      peak_pixel <= '0;
      peak_bin   <= '0;
      peak_count <= '0;
      drop_flag  <= 1'b0;
    end else begin
      ready   <= readyNext;
      closing <= closingNext;
      initCnt <= (state == INIT) ? initCnt + ADDR_W'(1) : '0;

      if (accept) begin
        if (pixCnt == PIX_W'(PIXEL_NUM - 1)) begin
          pixCnt <= '0;
          acqCnt <= (acqCnt == ACQ_W'(ACQ_NUM - 1)) ? '0 : acqCnt + ACQ_W'(1);
        end else begin
          pixCnt <= pixCnt + PIX_W'(1);
        end
      end

      scanBin <= (state == SCAN) ? scanBin + BIN_W'(1) : '0;
      if (transfer) scanPix <= lastPix ? '0 : scanPix + PIX_W'(1);

      // Running maximum; strict compare keeps the lowest bin on ties
      if (state == SCAN) begin
        if (scanLast) begin
          maxCnt <= '0;
          maxBin <= '0;
        end else if (scanHigher) begin
          maxCnt <= scanRd;
          maxBin <= scanBin;
        end
      end

      if (peakLoad) begin
        peak_valid <= 1'b1;
        peak_pixel <= scanPix;
        peak_bin   <= scanHigher ? scanBin : maxBin;
        peak_count <= scanHigher ? scanRd : maxCnt;
      end else if (transfer) begin
        peak_valid <= 1'b0;
      end

      if (wr_en && !ready) drop_flag <= 1'b1;
    end
  end

  // Two-stage increment pipeline with forwarding of an uncommitted result
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s1Valid <= 1'b0;
      s1Addr  <= '0;
      s2Valid <= 1'b0;
      s2Addr  <= '0;
      s2Data  <= '0;
    end else begin
      s1Valid <= accept && dataHit;
      s1Addr  <= {pixCnt, sampleBin};
      s2Valid <= s1Valid;
      s2Addr  <= s1Addr;
      s2Data  <= (s2Valid && (s2Addr == s1Addr)) ? incCnt(s2Data) : mem[s1Addr];
    end
  end

  // Single write port: clear during INIT and SCAN, increment commit during ACCUM
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[initCnt] <= '0;
    else if (state == SCAN)
      mem[scanAddr] <= '0;
    else if (s2Valid)
      mem[s2Addr] <= incCnt(s2Data);
  end

endmodule

// File: tb/tb_hist_builder_mp.sv
// Bench for hist_builder_mp: two instances (CNT_W=4 and CNT_W=2) share stimulus and are checked against a histogram model.
module tb_hist_builder_mp;

  localparam int NS    = 12;
  localparam int PIXN  = 3;
  localparam int BINSN = 64;
`ifdef HIST_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res;
  logic       wrEn;
  logic [9:0] data;
  logic       peakReady;

  logic       readyA, peakValidA, dropA;
  logic [1:0] peakPixelA;
  logic [5:0] peakBinA;
  logic [3:0] peakCountA;
  logic       readyB, peakValidB, dropB;
  logic [1:0] peakPixelB;
  logic [5:0] peakBinB;
  logic [1:0] peakCountB;

  int checks = 0;
  int failures = 0;
  int expBin [2][PIXN];
  int expCnt [2][PIXN];

  always #5 clk = ~clk;

  hist_builder_mp dutA (
    .clk(clk), .res(res), .wr_en(wrEn), .data(data), .ready(readyA),
    .peak_valid(peakValidA), .peak_ready(peakReady), .peak_pixel(peakPixelA),
    .peak_bin(peakBinA), .peak_count(peakCountA), .drop_flag(dropA)
  );

  hist_builder_mp #(.CNT_W(2)) dutB (
    .clk(clk), .res(res), .wr_en(wrEn), .data(data), .ready(readyB),
    .peak_valid(peakValidB), .peak_ready(peakReady), .peak_pixel(peakPixelB),
    .peak_bin(peakBinB), .peak_count(peakCountB), .drop_flag(dropB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: per-pixel bin histograms from the slot order, then first maximal bin
  task automatic buildModel(input int fr [NS]);
    for (int d = 0; d < 2; d++) begin
      int cmax;
      int cnt [PIXN][BINSN];
      cmax = (d == 0) ? 15 : 3;
      for (int p = 0; p < PIXN; p++)
        for (int b = 0; b < BINSN; b++) cnt[p][b] = 0;
      for (int s = 0; s < NS; s++) begin
        int p, b;
        p = s % PIXN;
        b = fr[s] / 16;
        if (fr[s] != 0) begin
          if (SAT) cnt[p][b] = (cnt[p][b] == cmax) ? cmax : cnt[p][b] + 1;
          else     cnt[p][b] = (cnt[p][b] + 1) % (cmax + 1);
        end
      end
      for (int p = 0; p < PIXN; p++) begin
        expBin[d][p] = 0;
        expCnt[d][p] = 0;
        for (int b = 0; b < BINSN; b++)
          if (cnt[p][b] > expCnt[d][p]) begin
            expCnt[d][p] = cnt[p][b];
            expBin[d][p] = b;
          end
      end
    end
  endtask

  task automatic resetAndCount();
    int n;
    res = 1'b1;
    wrEn = 1'b0;
    peakReady = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(readyA), 0);
    check("rst_valid", 32'(peakValidA), 0);
    check("rst_pixel", 32'(peakPixelA), 0);
    check("rst_bin", 32'(peakBinA), 0);
    check("rst_count", 32'(peakCountA), 0);
    check("rst_drop", 32'(dropA), 0);
    res = 1'b0;
    n = 0;
    while (!readyA && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("init_cycles", 32'(n), 192);
    check("init_ready_b", 32'(readyB), 1);
    @(negedge clk);
  endtask

  task automatic sendFrame(input int fr [NS], input int nSend, input int maxGap);
    int n;
    n = 0;
    while (!readyA && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(readyA), 1);
    for (int s = 0; s < nSend; s++) begin
      repeat ($urandom_range(0, maxGap)) begin
        wrEn = 1'b0;
        data = 10'($urandom);
        @(negedge clk);
      end
      wrEn = 1'b1;
      data = 10'(fr[s]);
      @(negedge clk);
    end
    wrEn = 1'b0;
    data = '0;
  endtask

  task automatic collect(input int stall, input bit dropPulse);
    for (int p = 0; p < PIXN; p++) begin
      int n;
      n = 0;
      while (!peakValidA && n < 300) begin
        wrEn = dropPulse && !readyA;
        @(negedge clk);
        n++;
      end
      wrEn = 1'b0;
      check("valid_a", 32'(peakValidA), 1);
      check("valid_b", 32'(peakValidB), 1);
      check("pixel_a", 32'(peakPixelA), 32'(p));
      check("bin_a", 32'(peakBinA), 32'(expBin[0][p]));
      check("count_a", 32'(peakCountA), 32'(expCnt[0][p]));
      check("bin_b", 32'(peakBinB), 32'(expBin[1][p]));
      check("count_b", 32'(peakCountB), 32'(expCnt[1][p]));
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_valid", 32'(peakValidA), 1);
        check("stall_pixel", 32'(peakPixelA), 32'(p));
        check("stall_bin", 32'(peakBinA), 32'(expBin[0][p]));
        check("stall_count", 32'(peakCountA), 32'(expCnt[0][p]));
      end
      peakReady = 1'b1;
      @(negedge clk);
      peakReady = 1'b0;
      check("valid_low", 32'(peakValidA), 0);
    end
    check("ready_back", 32'(readyA), 1);
  endtask

  initial begin
    int fr [NS];
    int ref33 [NS];
    res = 1'b1;
    wrEn = 1'b0;
    data = '0;
    peakReady = 1'b0;
    @(negedge clk);

    resetAndCount();

    ref33 = '{108, 511, 0, 108, 511, 0, 108, 511, 0, 108, 1022, 0};
    buildModel(ref33);
    sendFrame(ref33, NS, 2);
    collect(0, 1'b0);
    check("no_drop", 32'(dropA), 0);

    fr = '{160, 0, 0, 160, 0, 0, 80, 0, 0, 80, 0, 0};
    buildModel(fr);
    sendFrame(fr, NS, 0);
    collect(0, 1'b0);

    fr = '{108, 0, 0, 108, 0, 0, 108, 0, 0, 108, 0, 0};
    buildModel(fr);
    sendFrame(fr, NS, 1);
    collect(1, 1'b0);

    buildModel(ref33);
    sendFrame(ref33, NS, 0);
    collect(5, 1'b1);
    check("drop_set_a", 32'(dropA), 1);
    check("drop_set_b", 32'(dropB), 1);

    for (int f = 0; f < 6; f++) begin
      for (int s = 0; s < NS; s++) begin
        int bin;
        bin = $urandom_range(0, 1) ? int'($urandom_range(60, 63)) : int'($urandom_range(0, 3));
        fr[s] = ($urandom_range(0, 4) == 0) ? 0 : bin * 16 + int'($urandom_range(0, 15));
      end
      buildModel(fr);
      sendFrame(fr, NS, 3);
      collect(int'($urandom_range(0, 3)), 1'b0);
    end

    fr = '{400, 400, 400, 400, 400, 0, 0, 0, 0, 0, 0, 0};
    sendFrame(fr, 5, 0);
    resetAndCount();
    buildModel(ref33);
    sendFrame(ref33, NS, 1);
    collect(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hist_builder_mp.md
HIST_BUILDER_MP -- requirements
Module: hist_builder_mp

Interface
REQ-001 Parameter NP, 10: timestamp (TDC code) width.
REQ-002 Parameter BIN_W, 6: histogram bin-index width; BINS = 2^BIN_W; BIN_W <= NP.
REQ-003 Parameter PIXEL_NUM, 3: pixels interleaved per acquisition.
REQ-004 Parameter ACQ_NUM, 4: acquisitions per frame.
REQ-005 Parameter CNT_W, 4: bin counter width.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 res  in  1  reset, asynchronous, active-high.
REQ-008 wr_en  in  1  data qualifier.
REQ-009 data  in  NP  timestamp; value 0 = no detection.
REQ-010 ready  out  1  high only in ACCUM.
REQ-011 peak_valid  out  1  peak record present.
REQ-012 peak_ready  in  1  consumer accepts peak record.
REQ-013 peak_pixel  out  clog2(PIXEL_NUM)  pixel index of record.
REQ-014 peak_bin  out  BIN_W  bin with maximum count.
REQ-015 peak_count  out  CNT_W  count of that bin.
REQ-016 drop_flag  out  1  sticky: a sample was offered while ready low.

Function
REQ-017 States: INIT, ACCUM, SCAN, OUT; storage PIXEL_NUM x BINS counters of CNT_W bits.
REQ-018 INIT: write 0 to one location per cycle, PIXEL_NUM*BINS cycles, then ACCUM; ready low.
REQ-019 Accepted sample = wr_en && ready; assigned to pixel pix_cnt; pix_cnt wraps PIXEL_NUM-1 -> 0 and increments acq_cnt.
REQ-020 Bin index = data[NP-1 -: BIN_W]; data==0 consumes a slot (pix_cnt advances) with no increment.
REQ-021 Increment is a 2-stage read-modify-write; back-to-back hits on the same location (PIXEL_NUM=1) are forwarded, no lost counts.
REQ-022 Accepted sample at pix_cnt=PIXEL_NUM-1, acq_cnt=ACQ_NUM-1 moves ACCUM -> SCAN next cycle after its write commits; ready low from the following cycle.
REQ-023 SCAN: per pixel, read bins 0..BINS-1 one per cycle, track max with strict greater-than (ties -> lowest bin), write 0 to each bin after reading.
REQ-024 All-zero pixel -> peak_bin 0, peak_count 0.
REQ-025 After last bin of a pixel (at most BINS+2 cycles after scan start) -> OUT with peak_valid high.
REQ-026 OUT: peak_pixel/peak_bin/peak_count stable while peak_valid && !peak_ready; transfer on peak_valid && peak_ready; peak_valid low next cycle.
REQ-027 After transfer: next pixel -> SCAN; after pixel PIXEL_NUM-1 -> ACCUM with pix_cnt = acq_cnt = 0.
REQ-028 wr_en while ready low: sample ignored, drop_flag set, histogram unchanged.

Reset
REQ-029 res high: state INIT, pix_cnt/acq_cnt/scan counters 0, ready 0, peak_valid 0, peak_pixel/peak_bin/peak_count 0, drop_flag 0.
REQ-030 res mid-ACCUM/SCAN/OUT: pending record discarded, INIT re-clears all storage; no pre-reset count visible afterwards.

Configuration
REQ-031 Macro HIST_SAT_EN defined: counter at 2^CNT_W-1 holds on increment; undefined: counter wraps modulo 2^CNT_W.

Verification
REQ-032 Defaults, res pulse -> ready rises exactly 192 cycles after res deassertion.
REQ-033 Frame: pixel0 data 108 x4; pixel1 511 x3 then 1022 x1; pixel2 0 x4 -> records (0,6,4), (1,31,3), (2,0,0) in order.
REQ-034 Tie: pixel0 data 160,160,80,80 -> (0,5,2).
REQ-035 CNT_W=2, pixel0 data 108 x4 -> HIST_SAT_EN: (0,6,3); without: (0,0,0).
REQ-036 peak_ready low 5 cycles in OUT -> record fields unchanged; wr_en=1 during SCAN -> drop_flag=1, next frame counts unaffected.
REQ-037 res mid-ACCUM after 5 samples, then full frame of REQ-033 -> identical records to REQ-033.
